// File: rtl/fir_hilb_tdm.sv
// rtl/fir_hilb_tdm.sv - multi-channel time-multiplexed Hilbert FIR with one serial MAC
//
// Purpose: per-channel delay lines of 4*M-1 taps feed a single multiply-accumulate
// that walks the M unique antisymmetric coefficients, producing an analytic pair:
// re = input delayed to the group centre, im = saturated Hilbert-filtered value.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   s_valid/s_ready       input handshake; s_ch selects channel, s_data signed sample
//   coef[M][W]            signed Q2.(W-2); coef[k] = h[C-(2k+1)] = -h[C+(2k+1)]
//   m_valid/m_ready       output handshake
//   m_ch, m_re, m_im      channel tag, centre-delayed sample, Hilbert output
//   m_sat                 m_im was clipped on this output
module fir_hilb_tdm #(
    parameter int W   = 16,
    parameter int M   = 4,
    parameter int NCH = 2,
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [CHW-1:0]        s_ch,
    input  logic signed [W-1:0]   s_data,
    input  logic [M-1:0][W-1:0]   coef,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [CHW-1:0]        m_ch,
    output logic signed [W-1:0]   m_re,
    output logic signed [W-1:0]   m_im,
    output logic                  m_sat
);
    localparam int NTAP = 4 * M - 1;
    localparam int C    = 2 * M - 1;
    localparam int KW   = (M > 1) ? $clog2(M) : 1;
    localparam int AW   = 2 * W + 1 + $clog2(M);

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

    state_t                          state_q, state_d;
    logic [NCH-1:0][NTAP-1:0][W-1:0] line_q, line_d;
    logic [KW-1:0]                   k_q, k_d;
    logic signed [AW-1:0]            acc_q, acc_d;
    logic [CHW-1:0]                  ch_q, ch_d;
    logic                            m_valid_q, m_valid_d;
    logic [CHW-1:0]                  m_ch_q, m_ch_d;
    logic signed [W-1:0]             m_re_q, m_re_d;
    logic signed [W-1:0]             m_im_q, m_im_d;
    logic                            m_sat_q, m_sat_d;

    logic                            ch_ok;
    logic [W-1:0]                    tap_new, tap_old;
    logic signed [W-1:0]             coef_sel;
    logic signed [W:0]               pair;
    logic signed [2*W:0]             prod;
    logic signed [AW-1:0]            acc_next, acc_shr;
    logic                            im_sat;
    logic signed [W-1:0]             im_val;

    // Tags beyond NCH only exist when NCH is not a power of two.
    generate
        if ((1 << CHW) > NCH) begin : g_ch_check
            assign ch_ok = (32'(s_ch) < NCH);
        end else begin : g_ch_all
            assign ch_ok = 1'b1;
        end
    endgenerate

    // MAC datapath: symmetric tap pair around the centre, one coefficient per cycle.
    always_comb begin
        tap_new  = '0;
        tap_old  = '0;
        coef_sel = '0;
        for (int i = 0; i < M; i++) begin
            if (k_q == KW'(i)) begin
                tap_new  = line_q[ch_q][C-2*i-1];
                tap_old  = line_q[ch_q][C+2*i+1];
                coef_sel = coef[i];
            end
        end
        pair     = $signed({tap_new[W-1], tap_new}) - $signed({tap_old[W-1], tap_old});
        prod     = (2*W+1)'(pair) * (2*W+1)'(coef_sel);
        acc_next = acc_q + AW'(prod);
        // Floor shift back to sample scale; clip when the upper bits are not a pure sign extension.
        acc_shr  = acc_next >>> (W - 2);
        im_sat   = !((&acc_shr[AW-1:W-1]) || !(|acc_shr[AW-1:W-1]));
        if (im_sat) begin
            im_val = acc_shr[AW-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end else begin
            im_val = acc_shr[W-1:0];
        end
    end

    always_comb begin
        state_d   = state_q;
        line_d    = line_q;
        k_d       = k_q;
        acc_d     = acc_q;
        ch_d      = ch_q;
        m_valid_d = m_valid_q;
        m_ch_d    = m_ch_q;
        m_re_d    = m_re_q;
        m_im_d    = m_im_q;
        m_sat_d   = m_sat_q;
        s_ready   = (state_q == IDLE);
        unique case (state_q)
            IDLE: begin
                // An out-of-range tag is still consumed but leaves everything untouched.
                if (s_valid && ch_ok) begin
                    line_d[s_ch] = {line_q[s_ch][NTAP-2:0], s_data};
                    ch_d         = s_ch;
                    k_d          = '0;
                    acc_d        = '0;
                    state_d      = MAC;
                end
            end
            MAC: begin
                acc_d = acc_next;
                k_d   = k_q + 1'b1;
                if (k_q == KW'(M - 1)) begin
                    state_d   = OUT;
                    m_valid_d = 1'b1;
                    m_ch_d    = ch_q;
                    m_re_d    = line_q[ch_q][C];
                    m_im_d    = im_val;
                    m_sat_d   = im_sat;
                end
            end
            OUT: begin
                if (m_ready) begin
                    m_valid_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            line_q    <= '0;
            k_q       <= '0;
            acc_q     <= '0;
            ch_q      <= '0;
            m_valid_q <= 1'b0;
            m_ch_q    <= '0;
            m_re_q    <= '0;
            m_im_q    <= '0;
            m_sat_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            line_q    <= line_d;
            k_q       <= k_d;
            acc_q     <= acc_d;
            ch_q      <= ch_d;
            m_valid_q <= m_valid_d;
            m_ch_q    <= m_ch_d;
            m_re_q    <= m_re_d;
            m_im_q    <= m_im_d;
            m_sat_q   <= m_sat_d;
        end
    end

    assign m_valid = m_valid_q;
    assign m_ch    = m_ch_q;
    assign m_re    = m_re_q;
    assign m_im    = m_im_q;
    assign m_sat   = m_sat_q;

endmodule

// File: tb/tb_fir_hilb_tdm.sv
// tb/tb_fir_hilb_tdm.sv - scoreboard bench for fir_hilb_tdm
module tb_fir_hilb_tdm;
    localparam int W    = 16;
    localparam int M    = 4;
    localparam int NCH  = 2;
    localparam int CHW  = 1;
    localparam int C    = 2 * M - 1;
    localparam int NTAP = 4 * M - 1;
    localparam int MAXV = 2 ** (W - 1) - 1;
    localparam int MINV = -(2 ** (W - 1));

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 s_valid = 1'b0;
    logic                 s_ready;
    logic [CHW-1:0]       s_ch = '0;
    logic signed [W-1:0]  s_data = '0;
    logic [M-1:0][W-1:0]  coef = '0;
    logic                 m_valid;
    logic                 m_ready = 1'b1;
    logic [CHW-1:0]       m_ch;
    logic signed [W-1:0]  m_re;
    logic signed [W-1:0]  m_im;
    logic                 m_sat;

    fir_hilb_tdm #(.W(W), .M(M), .NCH(NCH)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_ch(s_ch), .s_data(s_data),
        .coef(coef),
        .m_valid(m_valid), .m_ready(m_ready), .m_ch(m_ch),
        .m_re(m_re), .m_im(m_im), .m_sat(m_sat)
    );

    always #5 clk = ~clk;

    typedef struct {
        int ch;
        int re;
        int im;
        int sat;
    } exp_t;

    exp_t expq[$];
    int   hist[NCH][$];
    int   got_im[NCH][$];
    int   got_re[NCH][$];
    int   got_sat[NCH][$];
    int   saved_im[$];
    int   saved_re[$];
    int   total = 0;
    int   bad = 0;
    int   pops = 0;
    int   mr_mode = 0;

    task automatic chk(input string name, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic int xl(input int ch, input int lag);
        if (lag < hist[ch].size()) return hist[ch][lag];
        return 0;
    endfunction

    // Reference: direct FIR sum over the antisymmetric taps, floor scaling, clamp.
    function automatic exp_t model(input int ch);
        longint acc = 0;
        exp_t   e;
        for (int k = 0; k < M; k++) begin
            int cv = int'($signed(coef[k]));
            acc += longint'(cv) * longint'(xl(ch, C - 2*k - 1) - xl(ch, C + 2*k + 1));
        end
        acc  = acc >>> (W - 2);
        e.ch = ch;
        e.re = xl(ch, C);
        if (acc > MAXV) begin
            e.im = MAXV; e.sat = 1;
        end else if (acc < MINV) begin
            e.im = MINV; e.sat = 1;
        end else begin
            e.im = int'(acc); e.sat = 0;
        end
        return e;
    endfunction

    task automatic clear_model();
        expq.delete();
        for (int c = 0; c < NCH; c++) begin
            hist[c].delete();
            got_im[c].delete();
            got_re[c].delete();
            got_sat[c].delete();
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        clear_model();
    endtask

    task automatic set_coef(input int c0, input int c1, input int c2, input int c3);
        coef[0] = W'(c0);
        coef[1] = W'(c1);
        coef[2] = W'(c2);
        coef[3] = W'(c3);
    endtask

    task automatic send(input int ch, input int data);
        int n = 0;
        while (!s_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!s_ready) begin
            chk("send_ready_timeout", s_ready, 1);
            return;
        end
        s_valid = 1'b1;
        s_ch    = CHW'(ch);
        s_data  = W'(data);
        hist[ch].push_front(data);
        if (hist[ch].size() > NTAP) void'(hist[ch].pop_back());
        expq.push_back(model(ch));
        @(posedge clk); #1;
        s_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((expq.size() != 0 || m_valid || !s_ready) && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_pending", expq.size(), 0);
    endtask

    task automatic run_impulse();
        set_coef(8192, 2731, 1638, 1170);
        send(0, 1000);
        for (int i = 0; i < 14; i++) send(0, 0);
        wait_drain();
    endtask

    // Random output backpressure when enabled.
    initial begin
        forever begin
            @(posedge clk); #1;
            if (mr_mode == 1) m_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: pops the scoreboard on each output transfer and checks hold under backpressure.
    initial begin
        exp_t                e;
        logic                held;
        logic [CHW-1:0]      h_ch;
        logic signed [W-1:0] h_re;
        logic signed [W-1:0] h_im;
        logic                h_sat;
        held = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                held = 1'b0;
            end else begin
                if (held) begin
                    chk("hold_valid", m_valid, 1);
                    chk("hold_ch", m_ch, h_ch);
                    chk("hold_re", m_re, h_re);
                    chk("hold_im", m_im, h_im);
                    chk("hold_sat", m_sat, h_sat);
                    chk("hold_s_ready", s_ready, 0);
                end
                held = 1'b0;
                if (m_valid && m_ready) begin
                    pops++;
                    if (expq.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_output actual ch=%0d im=%0d required=no output", m_ch, m_im);
                    end else begin
                        e = expq.pop_front();
                        chk("out_ch", m_ch, e.ch);
                        chk("out_re", m_re, e.re);
                        chk("out_im", m_im, e.im);
                        chk("out_sat", m_sat, e.sat);
                        got_im[e.ch].push_back(int'(m_im));
                        got_re[e.ch].push_back(int'(m_re));
                        got_sat[e.ch].push_back(int'(m_sat));
                    end
                end else if (m_valid) begin
                    held  = 1'b1;
                    h_ch  = m_ch;
                    h_re  = m_re;
                    h_im  = m_im;
                    h_sat = m_sat;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p;
        int n;
        int i0;
        int i1;
        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_s_ready", s_ready, 1);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_ch", m_ch, 0);
        chk("rst_m_re", m_re, 0);
        chk("rst_m_im", m_im, 0);
        chk("rst_m_sat", m_sat, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Impulse response against known values
        run_impulse();
        chk("t1_count", got_im[0].size(), 15);
        if (got_im[0].size() >= 11) begin
            chk("t1_im6", got_im[0][6], 500);
            chk("t1_im8", got_im[0][8], -500);
            chk("t1_im4", got_im[0][4], 166);
            chk("t1_im10", got_im[0][10], -167);
            chk("t1_im7", got_im[0][7], 0);
            chk("t1_re7", got_re[0][7], 1000);
        end
        saved_im = got_im[0];
        saved_re = got_re[0];

        // Timing: accept at cycle 0, output only at cycle M+1, ready again at M+2
        send(1, 777);
        for (int i = 1; i <= 6; i++) begin
            chk($sformatf("t2_s_ready_c%0d", i), s_ready, (i == 6));
            chk($sformatf("t2_m_valid_c%0d", i), m_valid, (i == 5));
            if (i < 6) begin
                @(posedge clk); #1;
            end
        end
        wait_drain();

        // Backpressure: 10 stalled cycles then a single transfer
        mr_mode = 2;
        m_ready = 1'b0;
        send(1, -555);
        n = 0;
        while (!m_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("t3_valid", m_valid, 1);
        p = pops;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("t3_s_ready", s_ready, 0);
            chk("t3_m_valid", m_valid, 1);
        end
        m_ready = 1'b1;
        @(posedge clk); #1;
        chk("t3_after_valid", m_valid, 0);
        chk("t3_after_s_ready", s_ready, 1);
        chk("t3_transfers", pops, p + 1);
        mr_mode = 0;
        wait_drain();

        // Saturation both directions
        do_reset();
        set_coef(16383, 16383, 16383, 16383);
        for (int i = 0; i < 7; i++) send(0, MINV);
        send(0, 0);
        for (int i = 0; i < 7; i++) send(0, MAXV);
        for (int i = 0; i < 7; i++) send(0, MAXV);
        send(0, 0);
        for (int i = 0; i < 7; i++) send(0, MINV);
        wait_drain();
        chk("t5_count", got_im[0].size(), 30);
        if (got_im[0].size() == 30) begin
            chk("t5_pos_im", got_im[0][14], MAXV);
            chk("t5_pos_sat", got_sat[0][14], 1);
            chk("t5_neg_im", got_im[0][29], MINV);
            chk("t5_neg_sat", got_sat[0][29], 1);
        end

        // Reset during MAC cycle 2 aborts, then a clean rerun of the impulse
        do_reset();
        set_coef(8192, 2731, 1638, 1170);
        send(0, 1234);
        @(posedge clk); #1;
        p = pops;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("t6_m_valid", m_valid, 0);
        chk("t6_s_ready", s_ready, 1);
        @(posedge clk); #1;
        rst = 1'b0;
        chk("t6_no_output", pops, p);
        clear_model();
        run_impulse();
        chk("t6_count", got_im[0].size(), saved_im.size());
        for (int i = 0; i < saved_im.size() && i < got_im[0].size(); i++) begin
            chk($sformatf("t6_im%0d", i), got_im[0][i], saved_im[i]);
            chk($sformatf("t6_re%0d", i), got_re[0][i], saved_re[i]);
        end

        // Two channels interleaved in random order
        do_reset();
        set_coef(8192, 2731, 1638, 1170);
        i0 = 0;
        i1 = 0;
        while (i0 < 15 || i1 < 15) begin
            if (i1 >= 15 || (i0 < 15 && $urandom_range(0, 1) == 0)) begin
                send(0, (i0 == 0) ? 1000 : 0);
                i0++;
            end else begin
                send(1, 1000);
                i1++;
            end
        end
        wait_drain();
        chk("t4_ch0_count", got_im[0].size(), 15);
        for (int i = 0; i < saved_im.size() && i < got_im[0].size(); i++) begin
            chk($sformatf("t4_ch0_im%0d", i), got_im[0][i], saved_im[i]);
        end
        chk("t4_ch1_count", got_im[1].size(), 15);
        if (got_im[1].size() == 15) begin
            chk("t4_ch1_im", got_im[1][14], 0);
            chk("t4_ch1_re", got_re[1][14], 1000);
        end

        // Random coefficients, data, channels and backpressure
        do_reset();
        for (int k = 0; k < M; k++) coef[k] = W'($urandom);
        mr_mode = 1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                send($urandom_range(0, NCH - 1), int'($signed(16'($urandom))));
            end else begin
                send($urandom_range(0, NCH - 1), int'($urandom_range(0, 4000)) - 2000);
            end
        end
        wait_drain();
        mr_mode = 0;
        m_ready = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
